// File: rtl/min_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : min_frame_sched
//  Brief    : Sequential minimum finder. One compare step per accepted sample
//             yields the frame minimum, its first position and the frame size.
//  Revision : 1.0  initial release
// ============================================================================
module min_frame_sched #(
    parameter int DATA_W = 8,
    parameter int N      = 3,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W-1:0]  out_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_last_pos = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_min;
    logic [DATA_W-1:0]   w_min_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    w_cnt_nxt;

    logic                w_acc;
    logic                w_less;
    logic                w_at_last;

    // in_ready depends on state only, so out_ready never reaches it combinationally
    assign in_ready  = (r_state != S_DONE);
    assign w_acc     = in_valid & in_ready;
    assign w_less    = (in_data < r_min);
    assign w_at_last = (r_cnt == c_last_pos);

    assign out_valid = (r_state == S_DONE);
    assign out_min   = r_min;
    assign out_idx   = r_idx;
    assign out_cnt   = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_min_nxt   = in_data;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = c_one;
                    w_state_nxt = in_last ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (w_acc) begin
                    // strict compare: ties keep the earliest position
                    if (w_less) begin
                        w_min_nxt = in_data;
                        w_idx_nxt = r_cnt;
                    end
                    w_cnt_nxt = r_cnt + c_one;
                    if (in_last || w_at_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_min   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/min_frame_sched.md
Name: min_frame_sched

Overview:
- Sequential minimum-finder controller. Time-shares one two-input "less-than, keep smaller" compare step across a frame of up to N byte samples delivered one per cycle.
- Sits upstream of consumers that need the minimum of a group plus the position where it occurred.
- Replaces a tree of parallel compare stages with a single compare step sequenced by a 3-state FSM.
- Uses valid/ready handshakes on both input and output.

Parameters:
- DATA_W, 8, sample width in bits.
- N, 3, maximum samples per frame (N >= 2).
- IDX_W, 2, width of index/count fields; must satisfy 2^IDX_W > N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  unsigned sample.
- in_last  input  1  accepted sample closes the frame early.
- out_valid  output  1  result held on out_*.
- out_ready  input  1  consumer takes the result this cycle.
- out_min  output  DATA_W  minimum of the frame (unsigned).
- out_idx  output  IDX_W  0-based position of the first occurrence of the minimum.
- out_cnt  output  IDX_W  number of samples in the frame (1..N).

Behaviour:
- Reset: on a clk edge with rst_n=0, state goes to IDLE and cnt, min_r, idx_r all clear to 0. Outputs after reset: out_valid=0, out_min=0, out_idx=0, out_cnt=0, in_ready=1. Reset mid-frame or mid-output discards all partial or pending data.
- States:
  - IDLE: no frame in progress.
  - ACC: frame in progress.
  - DONE: result pending.
- Accept condition: acc = in_valid & in_ready.
- in_ready is 1 in IDLE and ACC, 0 in DONE. There is no combinational path from out_ready to in_ready.
- IDLE, acc:
  - min_r <= in_data, idx_r <= 0, cnt <= 1.
  - If in_last=1, go to DONE; otherwise go to ACC.
- ACC, acc:
  - Compare step: if in_data < min_r (strict unsigned), then min_r <= in_data and idx_r <= cnt. Otherwise min_r and idx_r hold, so ties keep the earliest index.
  - cnt <= cnt+1.
  - Go to DONE if in_last=1 or cnt == N-1 (the N-th sample); otherwise stay in ACC.
- ACC, no acc: hold state and all registers indefinitely. There is no timeout.
- in_last on an IDLE beat produces a 1-sample frame.
- in_last is ignored when in_valid=0.
- The N-th sample ends the frame regardless of in_last.
- DONE:
  - out_valid=1, out_min=min_r, out_idx=idx_r, out_cnt=cnt.
  - All out_* are registered and stay stable until the handshake completes.
  - When out_ready=1: go to IDLE and clear cnt. out_valid is 0 on the next cycle, and in_ready returns to 1 that same next cycle.
- Outside DONE: out_valid=0, and out_min/out_idx/out_cnt show the register contents. Consumers must not use them when out_valid=0.
- Latency: out_valid rises on the cycle after the closing sample is accepted.
- Throughput: one sample per cycle within a frame; one bubble cycle minimum between frames (the DONE cycle).
- out_ready is ignored outside DONE.
- in_valid asserted while in DONE is not accepted. The sample is not lost; the source must hold it.
- Arithmetic: pure unsigned compare, no overflow possible. cnt never exceeds N.

Test Plan:
- Reset, then frame 5,3,9 (N=3, in_last=0, back-to-back, out_ready=1) -> out_valid on the cycle after the 9 beat with out_min=3, out_idx=1, out_cnt=3; out_valid=0 the following cycle; in_ready=0 only during the DONE cycle.
- Ties: frame 7,7,2 then 4,4,4 -> first result min=2, idx=2, cnt=3; second result min=4, idx=0 (earliest kept).
- Early end: 0xFF then 0x10 with in_last=1 on the second beat -> min=0x10, idx=1, cnt=2. Single beat 0x00 with in_last=1 in IDLE -> min=0, idx=0, cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles after the frame 8,1,6 -> out_valid=1 throughout with min=1, idx=1 stable and in_ready=0; a new in_valid sample is not accepted until the cycle after out_ready=1.
- Input gaps: frame 9,4,2 with in_valid dropped for 3 cycles between beats -> state held, result min=2, idx=2, cnt=3.
- Reset mid-frame: after accepting 1,2, assert rst_n=0 for one cycle -> out_* = 0 and in_ready=1; the next frame 6,5,4 yields min=4, idx=2, cnt=3 with no carry-over.
